decode_regread: RTL and testbench

//  Decode stage of the pipelined Y86-64 core: the read side of the register file that writeback updates.

---
 rtl/decode_regread_if.sv | 51 +++++
 rtl/decode_regread.sv | 133 +++++++++++++
 tb/tb_decode_regread.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regread_if.sv
// Decode/register-read bundle for the Y86-64 pipeline decode stage.
// Carries the D-stage instruction fields, the 15 architectural register
// values exported by writeback, the E/M/W forwarding sources, the E bubble
// control, and the registered E-stage outputs.
//   master : pipeline side (drives D fields, regfile view, forwarding, bubble)
//   slave  : decode_regread (drives d_srcA/d_srcB and the E register)
interface decode_regread_if;
    // D stage
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    // architectural register file contents from writeback
    logic [63:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
    logic [63:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
    logic [63:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;
    // forwarding sources
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    // pipeline control
    logic        E_bubble;
    // decode outputs
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
        output reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
        output reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14,
        output e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        output e_valE, M_valE, m_valM, W_valE, W_valM,
        output E_bubble,
        input  d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
        input  reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
        input  reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14,
        input  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        input  e_valE, M_valE, m_valM, W_valE, W_valM,
        input  E_bubble,
        output d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_regread.sv
// Y86-64 decode stage: register-ID decode, register-file read, E/M/W
// forwarding and the E pipeline register with bubble insertion.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; loads the E register with a bubble
//   bus   : decode_regread_if.slave (D fields, regfile view, forwarding
//           sources, E_bubble in; d_srcA/d_srcB and E register out)
module decode_regread #(
    parameter logic [3:0] RNONE    = 4'hF,
    parameter logic [3:0] RSP      = 4'h4,
    parameter logic [3:0] STAT_AOK = 4'h1
) (
    input  logic             clk,
    input  logic             reset,
    decode_regread_if.slave  bus
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b, val_a, val_b;
    logic [63:0] regs [15];

    assign regs[0]  = bus.reg_mem0;
    assign regs[1]  = bus.reg_mem1;
    assign regs[2]  = bus.reg_mem2;
    assign regs[3]  = bus.reg_mem3;
    assign regs[4]  = bus.reg_mem4;
    assign regs[5]  = bus.reg_mem5;
    assign regs[6]  = bus.reg_mem6;
    assign regs[7]  = bus.reg_mem7;
    assign regs[8]  = bus.reg_mem8;
    assign regs[9]  = bus.reg_mem9;
    assign regs[10] = bus.reg_mem10;
    assign regs[11] = bus.reg_mem11;
    assign regs[12] = bus.reg_mem12;
    assign regs[13] = bus.reg_mem13;
    assign regs[14] = bus.reg_mem14;

    // Register-ID decode. cmov keeps rB as dstE here; execute drops it on !cnd.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = bus.D_rA;
            I_RET, I_POPQ:                      src_a = RSP;
            default:                            ;
        endcase
        case (bus.D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = bus.D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP;
            default:                            ;
        endcase
        case (bus.D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = bus.D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP;
            default:                            ;
        endcase
        case (bus.D_icode)
            I_MRMOVQ, I_POPQ:                   dst_m = bus.D_rA;
            default:                            ;
        endcase
    end

    assign rf_a = (src_a == RNONE) ? '0 : regs[src_a];
    assign rf_b = (src_b == RNONE) ? '0 : regs[src_b];

    // Forwarding: youngest stage first. The RNONE guard stops an unused
    // source from matching a stage whose destination is also RNONE.
    always_comb begin
        val_a = rf_a;
        if (bus.D_icode == I_CALL || bus.D_icode == I_JXX)
            val_a = bus.D_valP;
        else if (src_a != RNONE) begin
            if      (src_a == bus.e_dstE) val_a = bus.e_valE;
            else if (src_a == bus.M_dstM) val_a = bus.m_valM;
            else if (src_a == bus.M_dstE) val_a = bus.M_valE;
            else if (src_a == bus.W_dstM) val_a = bus.W_valM;
            else if (src_a == bus.W_dstE) val_a = bus.W_valE;
        end
    end

    always_comb begin
        val_b = rf_b;
        if (src_b != RNONE) begin
            if      (src_b == bus.e_dstE) val_b = bus.e_valE;
            else if (src_b == bus.M_dstM) val_b = bus.m_valM;
            else if (src_b == bus.M_dstE) val_b = bus.M_valE;
            else if (src_b == bus.W_dstM) val_b = bus.W_valM;
            else if (src_b == bus.W_dstE) val_b = bus.W_valE;
        end
    end

    assign bus.d_srcA = src_a;
    assign bus.d_srcB = src_b;

    // Reset and bubble load identical nop contents, so one branch serves both.
    always_ff @(posedge clk) begin
        if (reset || bus.E_bubble) begin
            bus.E_stat  <= STAT_AOK;
            bus.E_icode <= I_NOP;
            bus.E_ifun  <= '0;
            bus.E_valC  <= '0;
            bus.E_valA  <= '0;
            bus.E_valB  <= '0;
            bus.E_dstE  <= RNONE;
            bus.E_dstM  <= RNONE;
            bus.E_srcA  <= RNONE;
            bus.E_srcB  <= RNONE;
        end else begin
            bus.E_stat  <= bus.D_stat;
            bus.E_icode <= bus.D_icode;
            bus.E_ifun  <= bus.D_ifun;
            bus.E_valC  <= bus.D_valC;
            bus.E_valA  <= val_a;
            bus.E_valB  <= val_b;
            bus.E_dstE  <= dst_e;
            bus.E_dstM  <= dst_m;
            bus.E_srcA  <= src_a;
            bus.E_srcB  <= src_b;
        end
    end
endmodule

// File: tb/tb_decode_regread.sv
// Self-checking bench for decode_regread: a directed vector table, a few
// hand-written multi-cycle sequences (latency, mid-stream reset/bubble) and
// randomized stimulus compared against a behavioural model.
module tb_decode_regread;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_regread_if bus ();

    decode_regread dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] rf [15];
    assign bus.reg_mem0  = rf[0];
    assign bus.reg_mem1  = rf[1];
    assign bus.reg_mem2  = rf[2];
    assign bus.reg_mem3  = rf[3];
    assign bus.reg_mem4  = rf[4];
    assign bus.reg_mem5  = rf[5];
    assign bus.reg_mem6  = rf[6];
    assign bus.reg_mem7  = rf[7];
    assign bus.reg_mem8  = rf[8];
    assign bus.reg_mem9  = rf[9];
    assign bus.reg_mem10 = rf[10];
    assign bus.reg_mem11 = rf[11];
    assign bus.reg_mem12 = rf[12];
    assign bus.reg_mem13 = rf[13];
    assign bus.reg_mem14 = rf[14];

    typedef struct {
        logic        reset, bubble;
        logic [3:0]  stat, icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
        logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    } in_t;

    typedef struct {
        in_t         in;
        logic [3:0]  x_srcA, x_srcB, x_dstE, x_dstM;
        logic [63:0] x_valA, x_valB;
    } vec_t;

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } e_t;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic e_t bubble_e();
        e_t x;
        x.stat = 4'h1; x.icode = 4'h1; x.ifun = 4'h0;
        x.valC = '0; x.valA = '0; x.valB = '0;
        x.dstE = 4'hF; x.dstM = 4'hF; x.srcA = 4'hF; x.srcB = 4'hF;
        return x;
    endfunction

    task automatic check_e(input string tag, input e_t x);
        check({tag, ".E_stat"},  bus.E_stat,  x.stat);
        check({tag, ".E_icode"}, bus.E_icode, x.icode);
        check({tag, ".E_ifun"},  bus.E_ifun,  x.ifun);
        check({tag, ".E_valC"},  bus.E_valC,  x.valC);
        check({tag, ".E_valA"},  bus.E_valA,  x.valA);
        check({tag, ".E_valB"},  bus.E_valB,  x.valB);
        check({tag, ".E_dstE"},  bus.E_dstE,  x.dstE);
        check({tag, ".E_dstM"},  bus.E_dstM,  x.dstM);
        check({tag, ".E_srcA"},  bus.E_srcA,  x.srcA);
        check({tag, ".E_srcB"},  bus.E_srcB,  x.srcB);
    endtask

    // ---------------- behavioural reference model ----------------
    // Bit n of each mask set = icode n uses that choice.
    localparam logic [15:0] SRCA_RA  = 16'h0454; // 2,4,6,A
    localparam logic [15:0] SRCA_RSP = 16'h0A00; // 9,B
    localparam logic [15:0] SRCB_RB  = 16'h0070; // 4,5,6
    localparam logic [15:0] ANY_RSP  = 16'h0F00; // 8,9,A,B
    localparam logic [15:0] DSTE_RB  = 16'h004C; // 2,3,6
    localparam logic [15:0] DSTM_RA  = 16'h0820; // 5,B
    localparam logic [15:0] USE_VALP = 16'h0180; // 7,8

    function automatic logic [3:0] pick(input logic [15:0] m_reg, input logic [15:0] m_rsp,
                                        input logic [3:0] icode, input logic [3:0] r);
        if (m_reg[icode]) return r;
        if (m_rsp[icode]) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [63:0] operand(input in_t i, input logic [3:0] id);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        if (id == 4'hF) return 64'h0;
        ids  = '{i.e_dstE, i.M_dstM, i.M_dstE, i.W_dstM, i.W_dstE};
        vals = '{i.e_valE, i.m_valM, i.M_valE, i.W_valM, i.W_valE};
        for (int k = 0; k < 5; k++)
            if (ids[k] == id) return vals[k];
        return rf[id];
    endfunction

    function automatic e_t model(input in_t i);
        e_t x;
        if (i.reset || i.bubble) return bubble_e();
        x.stat = i.stat; x.icode = i.icode; x.ifun = i.ifun; x.valC = i.valC;
        x.srcA = pick(SRCA_RA, SRCA_RSP, i.icode, i.rA);
        x.srcB = pick(SRCB_RB, ANY_RSP,  i.icode, i.rB);
        x.dstE = pick(DSTE_RB, ANY_RSP,  i.icode, i.rB);
        x.dstM = pick(DSTM_RA, 16'h0,    i.icode, i.rA);
        x.valA = USE_VALP[i.icode] ? i.valP : operand(i, x.srcA);
        x.valB = operand(i, x.srcB);
        return x;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic in_t blank_in();
        in_t i;
        i.reset = 0; i.bubble = 0;
        i.stat = 4'h1; i.icode = 4'h1; i.ifun = 4'h0; i.rA = 4'hF; i.rB = 4'hF;
        i.valC = '0; i.valP = '0;
        i.e_dstE = 4'hF; i.M_dstE = 4'hF; i.M_dstM = 4'hF; i.W_dstE = 4'hF; i.W_dstM = 4'hF;
        i.e_valE = '0; i.M_valE = '0; i.m_valM = '0; i.W_valE = '0; i.W_valM = '0;
        return i;
    endfunction

    function automatic vec_t blank_vec();
        vec_t v;
        v.in = blank_in();
        v.x_srcA = 4'hF; v.x_srcB = 4'hF; v.x_dstE = 4'hF; v.x_dstM = 4'hF;
        v.x_valA = '0; v.x_valB = '0;
        return v;
    endfunction

    task automatic drive(input in_t i);
        reset        = i.reset;
        bus.E_bubble = i.bubble;
        bus.D_stat   = i.stat;  bus.D_icode = i.icode; bus.D_ifun = i.ifun;
        bus.D_rA     = i.rA;    bus.D_rB    = i.rB;
        bus.D_valC   = i.valC;  bus.D_valP  = i.valP;
        bus.e_dstE   = i.e_dstE; bus.e_valE = i.e_valE;
        bus.M_dstE   = i.M_dstE; bus.M_valE = i.M_valE;
        bus.M_dstM   = i.M_dstM; bus.m_valM = i.m_valM;
        bus.W_dstE   = i.W_dstE; bus.W_valE = i.W_valE;
        bus.W_dstM   = i.W_dstM; bus.W_valM = i.W_valM;
    endtask

    function automatic logic [3:0] rand_id();
        int unsigned r = $urandom_range(0, 6);
        logic [3:0] id = r[3:0];
        return (r == 6) ? 4'hF : id;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    vec_t vecs [14];

    initial begin
        vec_t v;
        in_t  i;
        e_t   x;
        int unsigned n;

        for (int k = 0; k < 15; k++) rf[k] = 64'(k);

        // 0: reset loads a bubble
        v = blank_vec(); v.in.reset = 1; v.in.icode = 4'h6; v.in.rA = 4'h2; v.in.rB = 4'h3;
        v.x_srcA = 4'h2; v.x_srcB = 4'h3; vecs[0] = v;
        // 1: OPq, no hazards
        v = blank_vec(); v.in.icode = 4'h6; v.in.ifun = 4'h1; v.in.rA = 4'h2; v.in.rB = 4'h3;
        v.in.valC = 64'h1001;
        v.x_srcA = 4'h2; v.x_srcB = 4'h3; v.x_dstE = 4'h3; v.x_valA = 64'h2; v.x_valB = 64'h3; vecs[1] = v;
        // 2: OPq, e beats M
        v = blank_vec(); v.in.icode = 4'h6; v.in.rA = 4'h3; v.in.rB = 4'h1; v.in.stat = 4'h2;
        v.in.e_dstE = 4'h3; v.in.e_valE = 64'h55; v.in.M_dstE = 4'h3; v.in.M_valE = 64'h66;
        v.x_srcA = 4'h3; v.x_srcB = 4'h1; v.x_dstE = 4'h1; v.x_valA = 64'h55; v.x_valB = 64'h1; vecs[2] = v;
        // 3: popq, %rsp forwarded from W_dstM to both operands
        v = blank_vec(); v.in.icode = 4'hB; v.in.rA = 4'h5;
        v.in.W_dstM = 4'h4; v.in.W_valM = 64'h100;
        v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_dstM = 4'h5;
        v.x_valA = 64'h100; v.x_valB = 64'h100; vecs[3] = v;
        // 4: call uses valP
        v = blank_vec(); v.in.icode = 4'h8; v.in.valP = 64'h40; v.in.valC = 64'h2000;
        v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h40; v.x_valB = 64'h4; vecs[4] = v;
        // 5: irmovq rB=F; an RNONE e_dstE must not forward into an RNONE source
        v = blank_vec(); v.in.icode = 4'h3; v.in.valC = 64'hABCD;
        v.in.e_dstE = 4'hF; v.in.e_valE = 64'hDEAD; v.in.W_dstM = 4'hF; v.in.W_valM = 64'hBEEF;
        vecs[5] = v;
        // 6: bubble with a valid OPq in D
        v = blank_vec(); v.in.bubble = 1; v.in.icode = 4'h6; v.in.rA = 4'h2; v.in.rB = 4'h3;
        v.x_srcA = 4'h2; v.x_srcB = 4'h3; vecs[6] = v;
        // 7: rmmovq, M_dstM beats M_dstE; W_dstE feeds srcB
        v = blank_vec(); v.in.icode = 4'h4; v.in.rA = 4'h7; v.in.rB = 4'h2;
        v.in.M_dstM = 4'h7; v.in.m_valM = 64'h77; v.in.M_dstE = 4'h7; v.in.M_valE = 64'h88;
        v.in.W_dstE = 4'h2; v.in.W_valE = 64'h22;
        v.x_srcA = 4'h7; v.x_srcB = 4'h2; v.x_valA = 64'h77; v.x_valB = 64'h22; vecs[7] = v;
        // 8: OPq, W_dstM beats W_dstE; top register 14 read from regfile
        v = blank_vec(); v.in.icode = 4'h6; v.in.rA = 4'h9; v.in.rB = 4'hE;
        v.in.W_dstM = 4'h9; v.in.W_valM = 64'h99; v.in.W_dstE = 4'h9; v.in.W_valE = 64'hAA;
        v.x_srcA = 4'h9; v.x_srcB = 4'hE; v.x_dstE = 4'hE; v.x_valA = 64'h99; v.x_valB = 64'hE; vecs[8] = v;
        // 9: jXX uses valP, ignores rA
        v = blank_vec(); v.in.icode = 4'h7; v.in.ifun = 4'h3; v.in.rA = 4'h3; v.in.valP = 64'h1234;
        v.in.valC = 64'h3000;
        v.x_valA = 64'h1234; vecs[9] = v;
        // 10: ret
        v = blank_vec(); v.in.icode = 4'h9;
        v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h4; v.x_valB = 64'h4; vecs[10] = v;
        // 11: cmovXX keeps rB as dstE
        v = blank_vec(); v.in.icode = 4'h2; v.in.ifun = 4'h4; v.in.rA = 4'h1; v.in.rB = 4'h6;
        v.x_srcA = 4'h1; v.x_dstE = 4'h6; v.x_valA = 64'h1; vecs[11] = v;
        // 12: mrmovq
        v = blank_vec(); v.in.icode = 4'h5; v.in.rA = 4'h8; v.in.rB = 4'h3;
        v.x_srcB = 4'h3; v.x_dstM = 4'h8; v.x_valB = 64'h3; vecs[12] = v;
        // 13: pushq, register 0 read
        v = blank_vec(); v.in.icode = 4'hA; v.in.rA = 4'h0;
        v.x_srcA = 4'h0; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h0; v.x_valB = 64'h4; vecs[13] = v;

        drive(blank_in());
        reset = 1'b1;

        // ---------------- directed table ----------------
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].in);
            #1;
            check($sformatf("v%0d.d_srcA", k), bus.d_srcA, vecs[k].x_srcA);
            check($sformatf("v%0d.d_srcB", k), bus.d_srcB, vecs[k].x_srcB);
            if (vecs[k].in.reset || vecs[k].in.bubble) x = bubble_e();
            else begin
                x.stat = vecs[k].in.stat; x.icode = vecs[k].in.icode; x.ifun = vecs[k].in.ifun;
                x.valC = vecs[k].in.valC; x.valA = vecs[k].x_valA;    x.valB = vecs[k].x_valB;
                x.dstE = vecs[k].x_dstE;  x.dstM = vecs[k].x_dstM;
                x.srcA = vecs[k].x_srcA;  x.srcB = vecs[k].x_srcB;
            end
            @(posedge clk); #1;
            check_e($sformatf("v%0d", k), x);
        end

        // ---------------- latency: E holds until the next edge ----------------
        @(negedge clk);
        i = vecs[1].in; drive(i); x = model(i);
        @(posedge clk); #1;
        check_e("lat.load", x);
        @(negedge clk);
        i = blank_in(); i.icode = 4'h7; i.valC = 64'hBEEF; i.valP = 64'h77; drive(i);
        #1;
        check("lat.hold_valC", bus.E_valC, 64'h1001);
        check("lat.hold_icode", bus.E_icode, 4'h6);
        @(posedge clk); #1;
        check("lat.next_valC", bus.E_valC, 64'hBEEF);
        check("lat.next_valA", bus.E_valA, 64'h77);

        // ---------------- reset mid-stream overrides load, and bubble ----------------
        @(negedge clk);
        i = vecs[7].in; i.reset = 1; drive(i);
        @(posedge clk); #1;
        check_e("midrst", bubble_e());
        @(negedge clk);
        i.bubble = 1; drive(i);
        @(posedge clk); #1;
        check_e("rst_bub", bubble_e());
        @(negedge clk);
        i.reset = 0; i.bubble = 0; drive(i);
        @(posedge clk); #1;
        check("after_rst.E_valA", bus.E_valA, 64'h77);
        check("after_rst.E_icode", bus.E_icode, 4'h4);

        // ---------------- randomized against the model ----------------
        n = 0;
        repeat (400) begin
            @(negedge clk);
            for (int k = 0; k < 15; k++) rf[k] = rand64();
            i = blank_in();
            i.reset  = ($urandom_range(0, 29) == 0);
            i.bubble = ($urandom_range(0, 9) == 0);
            i.stat   = 4'($urandom_range(0, 15));
            i.icode  = 4'($urandom_range(0, 15));
            i.ifun   = 4'($urandom_range(0, 15));
            i.rA = rand_id(); i.rB = rand_id();
            i.valC = rand64(); i.valP = rand64();
            i.e_dstE = rand_id(); i.M_dstE = rand_id(); i.M_dstM = rand_id();
            i.W_dstE = rand_id(); i.W_dstM = rand_id();
            i.e_valE = rand64(); i.M_valE = rand64(); i.m_valM = rand64();
            i.W_valE = rand64(); i.W_valM = rand64();
            drive(i);
            #1;
            x = model(blank_in());
            begin
                in_t nb;
                nb = i; nb.reset = 0; nb.bubble = 0;
                x = model(nb);
            end
            check($sformatf("r%0d.d_srcA", n), bus.d_srcA, x.srcA);
            check($sformatf("r%0d.d_srcB", n), bus.d_srcB, x.srcB);
            x = model(i);
            @(posedge clk); #1;
            check_e($sformatf("r%0d", n), x);
            n++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
